// File: rtl/tdm_demux_14_4bit_pkg.sv
// Shared types and constants for the 4-slot TDM receive path.
// Slot indices match the order channels appear on the bus after a sync marker.
package tdm_demux_14_4bit_pkg;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_ERR_CNT_W = 8;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/tdm_slot_counter.sv
// 2-bit wrapping slot counter: advances on en, jumps to slot 1 when en and sync coincide.
// Registered count, no backpressure; last flags the slot that completes a frame.
module tdm_slot_counter
    import tdm_demux_14_4bit_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       sync,
    output logic [1:0] slot,
    output logic       last
);

    logic [1:0] slot_d;
    logic [1:0] slot_q;

    // The sync word itself occupies slot 0, so the next expected slot is 1.
    always_comb begin
        slot_d = slot_q;
        if (en) begin
            slot_d = sync ? SLOT_B : slot_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q <= SLOT_A;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign slot = slot_q;
    assign last = (slot_q == SLOT_D);

endmodule

// File: rtl/tdm_demux_14_4bit.sv
// Demultiplexes a 4-slot TDM word stream into channels A..D, publishing whole frames only.
// 1 clock from the slot-3 word to updated outputs; no backpressure, Valid_in qualifies each word.
module tdm_demux_14_4bit
    import tdm_demux_14_4bit_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ERR_CNT_W = DEF_ERR_CNT_W
) (
    input  logic                 Clk_in,
    input  logic                 Reset_n_in,
    input  logic [WIDTH-1:0]     Data_in,
    input  logic                 Valid_in,
    input  logic                 Sync_in,
    output logic [WIDTH-1:0]     A_out,
    output logic [WIDTH-1:0]     B_out,
    output logic [WIDTH-1:0]     C_out,
    output logic [WIDTH-1:0]     D_out,
    output logic                 Frame_valid_out,
    output logic                 Locked_out,
    output logic [1:0]           Slot_out,
    output logic                 Sync_err_out,
    output logic [ERR_CNT_W-1:0] Err_count_out
);

    localparam logic [ERR_CNT_W-1:0] ERR_ONE = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

    state_e               state_d, state_q;
    logic [WIDTH-1:0]     sh0_d, sh0_q, sh1_d, sh1_q, sh2_d, sh2_q;
    logic [WIDTH-1:0]     a_d, a_q, b_d, b_q, c_d, c_q, d_d, d_q;
    logic                 frame_vld_d, frame_vld_q;
    logic                 locked_d, locked_q;
    logic                 sync_err_d, sync_err_q;
    logic [ERR_CNT_W-1:0] err_cnt_d, err_cnt_q;

    logic       is_locked;
    logic       wr_en;
    logic       misalign;
    logic       complete;
    logic [1:0] slot;
    logic [1:0] wr_slot;
    logic       last_slot;

    assign is_locked = (state_q == LOCKED);
    // In HUNT only a sync word is accepted; everything else is discarded.
    assign wr_en     = Valid_in && (is_locked || Sync_in);
    assign wr_slot   = Sync_in ? SLOT_A : slot;
    assign misalign  = Valid_in && is_locked && Sync_in && (slot != SLOT_A);
    // A sync can never land on slot 3 as a completion: it restarts the frame instead.
    assign complete  = Valid_in && is_locked && !Sync_in && last_slot;

    tdm_slot_counter u_slot_counter (
        .clk   (Clk_in),
        .rst_n (Reset_n_in),
        .en    (wr_en),
        .sync  (Sync_in),
        .slot  (slot),
        .last  (last_slot)
    );

    always_comb begin
        state_d     = state_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        d_d         = d_q;
        frame_vld_d = complete;
        sync_err_d  = misalign;
        locked_d    = is_locked;
        err_cnt_d   = err_cnt_q;

        if (Valid_in && Sync_in) begin
            state_d = LOCKED;
        end

        if (wr_en) begin
            case (wr_slot)
                SLOT_A:  sh0_d = Data_in;
                SLOT_B:  sh1_d = Data_in;
                SLOT_C:  sh2_d = Data_in;
                default: ;
            endcase
        end

        if (complete) begin
            a_d = sh0_q;
            b_d = sh1_q;
            c_d = sh2_q;
            d_d = Data_in;
        end

        if (misalign && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + ERR_ONE;
        end
    end

    always_ff @(posedge Clk_in) begin
        if (!Reset_n_in) begin
            state_q     <= HUNT;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            d_q         <= '0;
            frame_vld_q <= 1'b0;
            locked_q    <= 1'b0;
            sync_err_q  <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            d_q         <= d_d;
            frame_vld_q <= frame_vld_d;
            locked_q    <= locked_d;
            sync_err_q  <= sync_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign A_out           = a_q;
    assign B_out           = b_q;
    assign C_out           = c_q;
    assign D_out           = d_q;
    assign Frame_valid_out = frame_vld_q;
    assign Locked_out      = locked_q;
    assign Slot_out        = slot;
    assign Sync_err_out    = sync_err_q;
    assign Err_count_out   = err_cnt_q;

endmodule
